// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One operation in flight; WIDTH step cycles plus one sign-fix cycle per op.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic             is_div_q;
  logic             neg_res;
  logic             neg_rem;
  logic             b_zero;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic               op_signed_c;
  logic [WIDTH-1:0]   a_mag_c;
  logic [WIDTH-1:0]   b_mag_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH:0]     div_shift_c;
  logic [WIDTH:0]     div_diff_c;
  logic [WIDTH-1:0]   hi_nx_c;
  logic [WIDTH-1:0]   lo_nx_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [2*WIDTH-1:0] prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;

  // Operand magnitudes at acceptance; signed ops work on absolute values.
  always_comb begin
    op_signed_c = ~op[0];
    a_mag_c     = (op_signed_c && a[WIDTH-1]) ? -a : a;
    b_mag_c     = (op_signed_c && b[WIDTH-1]) ? -b : b;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  // Multiply: acc_hi:acc_lo holds partial product / remaining multiplier bits.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum_c   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb_q : {WIDTH{1'b0}})};
    div_shift_c = {acc_hi, acc_lo[WIDTH-1]};
    div_diff_c  = div_shift_c - {1'b0, opb_q};
    hi_nx_c     = mul_sum_c[WIDTH:1];
    lo_nx_c     = {mul_sum_c[0], acc_lo[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_diff_c[WIDTH]) begin
        hi_nx_c = div_diff_c[WIDTH-1:0];
        lo_nx_c = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx_c = div_shift_c[WIDTH-1:0];
        lo_nx_c = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod_c     = {acc_hi, acc_lo};
    prod_fix_c = neg_res ? -prod_c : prod_c;
    quo_fix_c  = neg_res ? -acc_lo : acc_lo;
    rem_fix_c  = neg_rem ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      is_div_q    <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
      count       <= '0;
      a_q         <= '0;
      opb_q       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div_q <= op[1];
            neg_res  <= op_signed_c & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= op_signed_c & a[WIDTH-1];
            b_zero   <= (b == '0);
            a_q      <= a;
            opb_q    <= b_mag_c;
            acc_hi   <= '0;
            acc_lo   <= a_mag_c;
            count    <= CW'(WIDTH - 1);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc_hi <= hi_nx_c;
          acc_lo <= lo_nx_c;
          count  <= count - CW'(1);
          if (count == '0) state <= FIX;
        end
        FIX: begin
          if (is_div_q) begin
            if (b_zero) begin
              lo          <= '1;
              hi          <= a_q;
              div_by_zero <= 1'b1;
            end else begin
              lo <= quo_fix_c;
              hi <= rem_fix_c;
            end
          end else begin
            hi <= prod_fix_c[2*WIDTH-1:WIDTH];
            lo <= prod_fix_c[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
